// File: rtl/udp_rx_parser.sv
// Purpose: strips preamble/Ethernet/IPv4/UDP headers from the GMII rx stream and emits UDP payload for the board's MAC/IP/port.
// Latency: 1 e_rxc cycle from a payload byte on e_rxd to data_o/data_o_valid; frame_start 1 cycle after the last UDP header byte.
// Backpressure: none; GMII cannot be stalled, so payload leaves at line rate and loss of e_rxdv aborts the frame.
module udp_rx_parser #(
  parameter logic [47:0] BOARD_MAC  = 48'h000A3501FEC0,
  parameter logic [31:0] BOARD_IP   = 32'hC0A80002,
  parameter logic [15:0] BOARD_PORT = 16'd8080
) (
  input  logic        e_rxc,
  input  logic        reset_n,
  input  logic [7:0]  e_rxd,
  input  logic        e_rxdv,
  output logic [7:0]  data_o,
  output logic        data_o_valid,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] rx_data_length,
  output logic [31:0] rx_src_ip,
  output logic [15:0] rx_src_port
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, DATA, DROP} state_t;

  state_t      state_q, state_d;
  logic [4:0]  hdr_cnt_q, hdr_cnt_d;
  logic [15:0] pay_cnt_q, pay_cnt_d;
  logic        mac_uc_q, mac_uc_d, mac_bc_q, mac_bc_d;
  logic [31:0] sip_sh_q, sip_sh_d;
  logic [15:0] sport_sh_q, sport_sh_d;
  logic [15:0] udp_len_q, udp_len_d;
  logic [7:0]  data_o_q, data_o_d;
  logic        data_vld_q, data_vld_d;
  logic        start_q, start_d, done_q, done_d, err_q, err_d;
  logic [15:0] len_q, len_d;
  logic [31:0] src_ip_q, src_ip_d;
  logic [15:0] src_port_q, src_port_d;

  logic [7:0]  mac_byte, ip_byte, port_byte;
  logic        hdr_bad, mac_uc_hit, mac_bc_hit;
  logic [15:0] udp_len_now, pay_cnt_inc;

  // Reference byte of the board address fields at the current header offset
  always_comb begin
    mac_byte = 8'h00;
    case (hdr_cnt_q[2:0])
      3'd0:    mac_byte = BOARD_MAC[47:40];
      3'd1:    mac_byte = BOARD_MAC[39:32];
      3'd2:    mac_byte = BOARD_MAC[31:24];
      3'd3:    mac_byte = BOARD_MAC[23:16];
      3'd4:    mac_byte = BOARD_MAC[15:8];
      3'd5:    mac_byte = BOARD_MAC[7:0];
      default: mac_byte = 8'h00;
    endcase
    case (hdr_cnt_q[1:0])
      2'd0:    ip_byte = BOARD_IP[31:24];
      2'd1:    ip_byte = BOARD_IP[23:16];
      2'd2:    ip_byte = BOARD_IP[15:8];
      default: ip_byte = BOARD_IP[7:0];
    endcase
    port_byte = hdr_cnt_q[0] ? BOARD_PORT[7:0] : BOARD_PORT[15:8];
  end

  // Parser next-state, header checks, shadow capture and output pulses
  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    pay_cnt_d   = pay_cnt_q;
    mac_uc_d    = mac_uc_q;
    mac_bc_d    = mac_bc_q;
    sip_sh_d    = sip_sh_q;
    sport_sh_d  = sport_sh_q;
    udp_len_d   = udp_len_q;
    data_o_d    = data_o_q;
    data_vld_d  = 1'b0;
    start_d     = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    len_d       = len_q;
    src_ip_d    = src_ip_q;
    src_port_d  = src_port_q;
    hdr_bad     = 1'b0;
    mac_uc_hit  = mac_uc_q && (e_rxd == mac_byte);
    mac_bc_hit  = mac_bc_q && (e_rxd == 8'hFF);
    udp_len_now = {udp_len_q[15:8], e_rxd};
    pay_cnt_inc = pay_cnt_q + 16'd1;

    if (!e_rxdv) begin
      // Loss of carrier always returns to IDLE; only a payload in flight is reported.
      state_d = IDLE;
      err_d   = (state_q == DATA);
    end else begin
      case (state_q)
        IDLE: state_d = (e_rxd == 8'h55) ? PREAMBLE : DROP;
        PREAMBLE: begin
          if (e_rxd == 8'hD5) begin
            state_d   = ETH_HDR;
            hdr_cnt_d = 5'd0;
            mac_uc_d  = 1'b1;
            mac_bc_d  = 1'b1;
          end else if (e_rxd != 8'h55) begin
            state_d = DROP;
          end
        end
        ETH_HDR: begin
          hdr_cnt_d = hdr_cnt_q + 5'd1;
          // Unicast and broadcast matches are tracked separately so a mixed address is rejected.
          if (hdr_cnt_q < 5'd6) begin
            mac_uc_d = mac_uc_hit;
            mac_bc_d = mac_bc_hit;
            hdr_bad  = !(mac_uc_hit || mac_bc_hit);
          end
          if (hdr_cnt_q == 5'd12) hdr_bad = (e_rxd != 8'h08);
          if (hdr_cnt_q == 5'd13) hdr_bad = (e_rxd != 8'h00);
          if (hdr_bad) begin
            state_d = DROP;
          end else if (hdr_cnt_q == 5'd13) begin
            state_d   = IP_HDR;
            hdr_cnt_d = 5'd0;
          end
        end
        IP_HDR: begin
          hdr_cnt_d = hdr_cnt_q + 5'd1;
          if (hdr_cnt_q == 5'd0) hdr_bad = (e_rxd != 8'h45);
          if (hdr_cnt_q == 5'd9) hdr_bad = (e_rxd != 8'h11);
          if (hdr_cnt_q >= 5'd12 && hdr_cnt_q <= 5'd15) sip_sh_d = {sip_sh_q[23:0], e_rxd};
          if (hdr_cnt_q >= 5'd16) hdr_bad = (e_rxd != ip_byte);
          if (hdr_bad) begin
            state_d = DROP;
          end else if (hdr_cnt_q == 5'd19) begin
            state_d   = UDP_HDR;
            hdr_cnt_d = 5'd0;
          end
        end
        UDP_HDR: begin
          hdr_cnt_d = hdr_cnt_q + 5'd1;
          if (hdr_cnt_q <= 5'd1) sport_sh_d = {sport_sh_q[7:0], e_rxd};
          if (hdr_cnt_q == 5'd2 || hdr_cnt_q == 5'd3) hdr_bad = (e_rxd != port_byte);
          if (hdr_cnt_q == 5'd4) udp_len_d = {e_rxd, 8'h00};
          if (hdr_cnt_q == 5'd5) begin
            udp_len_d = udp_len_now;
            hdr_bad   = (udp_len_now < 16'd8);
          end
          if (hdr_bad) begin
            state_d = DROP;
          end else if (hdr_cnt_q == 5'd7) begin
            // Frame accepted: publish its attributes together with frame_start.
            len_d      = udp_len_q - 16'd8;
            src_ip_d   = sip_sh_q;
            src_port_d = sport_sh_q;
            start_d    = 1'b1;
            pay_cnt_d  = 16'd0;
            if (udp_len_q == 16'd8) begin
              done_d  = 1'b1;
              state_d = DROP;
            end else begin
              state_d = DATA;
            end
          end
        end
        DATA: begin
          data_o_d   = e_rxd;
          data_vld_d = 1'b1;
          pay_cnt_d  = pay_cnt_inc;
          // Anything after the declared length is Ethernet pad/FCS and is swallowed in DROP.
          if (pay_cnt_inc == len_q) begin
            done_d  = 1'b1;
            state_d = DROP;
          end
        end
        DROP:    state_d = DROP;
        default: state_d = DROP;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge e_rxc or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hdr_cnt_q  <= 5'd0;
      pay_cnt_q  <= 16'd0;
      mac_uc_q   <= 1'b0;
      mac_bc_q   <= 1'b0;
      sip_sh_q   <= 32'd0;
      sport_sh_q <= 16'd0;
      udp_len_q  <= 16'd0;
      data_o_q   <= 8'd0;
      data_vld_q <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      len_q      <= 16'd0;
      src_ip_q   <= 32'd0;
      src_port_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      pay_cnt_q  <= pay_cnt_d;
      mac_uc_q   <= mac_uc_d;
      mac_bc_q   <= mac_bc_d;
      sip_sh_q   <= sip_sh_d;
      sport_sh_q <= sport_sh_d;
      udp_len_q  <= udp_len_d;
      data_o_q   <= data_o_d;
      data_vld_q <= data_vld_d;
      start_q    <= start_d;
      done_q     <= done_d;
      err_q      <= err_d;
      len_q      <= len_d;
      src_ip_q   <= src_ip_d;
      src_port_q <= src_port_d;
    end
  end

  assign data_o         = data_o_q;
  assign data_o_valid   = data_vld_q;
  assign frame_start    = start_q;
  assign frame_done     = done_q;
  assign frame_err      = err_q;
  assign rx_data_length = len_q;
  assign rx_src_ip      = src_ip_q;
  assign rx_src_port    = src_port_q;

endmodule

// File: tb/tb_udp_rx_parser.sv
module tb_udp_rx_parser;

  localparam logic [47:0] MAC   = 48'h000A3501FEC0;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
  localparam logic [31:0] IP    = 32'hC0A80002;
  localparam logic [15:0] PORT  = 16'd8080;

  logic        e_rxc;
  logic        reset_n;
  logic [7:0]  e_rxd;
  logic        e_rxdv;
  logic [7:0]  data_o;
  logic        data_o_valid, frame_start, frame_done, frame_err;
  logic [15:0] rx_data_length;
  logic [31:0] rx_src_ip;
  logic [15:0] rx_src_port;

  udp_rx_parser dut (
    .e_rxc(e_rxc), .reset_n(reset_n), .e_rxd(e_rxd), .e_rxdv(e_rxdv),
    .data_o(data_o), .data_o_valid(data_o_valid), .frame_start(frame_start),
    .frame_done(frame_done), .frame_err(frame_err), .rx_data_length(rx_data_length),
    .rx_src_ip(rx_src_ip), .rx_src_port(rx_src_port)
  );

  initial e_rxc = 1'b0;
  always #4 e_rxc = ~e_rxc;

  int cyc = 0;
  always @(posedge e_rxc) cyc <= cyc + 1;

  // One expected output cycle, tied to the stream byte index whose arrival produces it.
  typedef struct {
    int          idx;
    logic        vld;
    logic [7:0]  dat;
    logic        st;
    logic        dn;
    logic        er;
    logic [15:0] len;
    logic [31:0] sip;
    logic [15:0] sport;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_e;
  int          drv_cyc[0:2047];
  logic [7:0]  fb[$];
  int          checks = 0;
  int          errors = 0;
  int          vld_cnt = 0;
  bit          mon_en = 1'b1;
  logic [15:0] h_len = 16'd0;
  logic [31:0] h_sip = 32'd0;
  logic [15:0] h_sport = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rnd8();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'h55) b = 8'h56;
    return b;
  endfunction

  task automatic push_be(input logic [47:0] v, input int nb);
    for (int k = nb - 1; k >= 0; k--) fb.push_back(8'(v >> (8 * k)));
  endtask

  // Assemble preamble + Ethernet + IPv4 + UDP + payload, padded to 60 bytes, plus 4 FCS bytes.
  task automatic build(input int pre_n, input logic [47:0] dmac, input logic [15:0] etype,
                       input logic [7:0] vihl, input logic [7:0] proto, input logic [31:0] dip,
                       input logic [31:0] sip, input logic [15:0] sport, input logic [15:0] dport,
                       input logic [15:0] ulen, input int plen);
    logic [15:0] tl;
    tl = ulen + 16'd20;
    fb.delete();
    repeat (pre_n) fb.push_back(8'h55);
    fb.push_back(8'hD5);
    push_be(dmac, 6);
    push_be(48'h02AABBCCDDEE, 6);
    push_be({32'h0, etype}, 2);
    fb.push_back(vihl);
    fb.push_back(8'h00);
    push_be({32'h0, tl}, 2);
    push_be(48'h1234, 2);
    push_be(48'h4000, 2);
    fb.push_back(8'h40);
    fb.push_back(proto);
    push_be(48'($urandom_range(0, 65535)), 2);
    push_be({16'h0, sip}, 4);
    push_be({16'h0, dip}, 4);
    push_be({32'h0, sport}, 2);
    push_be({32'h0, dport}, 2);
    push_be({32'h0, ulen}, 2);
    push_be(48'($urandom_range(0, 65535)), 2);
    repeat (plen) fb.push_back(rnd8());
    while (fb.size() - pre_n - 1 < 60) fb.push_back(rnd8());
    repeat (4) fb.push_back(rnd8());
  endtask

  // Reference: decide acceptance from the header fields of the first n bytes of fb and list the outputs.
  task automatic model(input int n);
    int i, h;
    logic [47:0] dst;
    logic [31:0] dip, sip;
    logic [15:0] dport, sport, ulen, plen;
    ev_t e;
    if (n < 1 || fb[0] != 8'h55) return;
    i = 1;
    while (i < n && fb[i] == 8'h55) i++;
    if (i >= n || fb[i] != 8'hD5) return;
    h = i + 1;
    if (n < h + 42) return;
    dst = 48'h0; dip = 32'h0; sip = 32'h0;
    for (int k = 0; k < 6; k++) dst = {dst[39:0], fb[h + k]};
    for (int k = 0; k < 4; k++) sip = {sip[23:0], fb[h + 26 + k]};
    for (int k = 0; k < 4; k++) dip = {dip[23:0], fb[h + 30 + k]};
    sport = {fb[h + 34], fb[h + 35]};
    dport = {fb[h + 36], fb[h + 37]};
    ulen  = {fb[h + 38], fb[h + 39]};
    if (!(dst == MAC || dst == BCAST)) return;
    if ({fb[h + 12], fb[h + 13]} != 16'h0800) return;
    if (fb[h + 14] != 8'h45 || fb[h + 23] != 8'h11) return;
    if (dip != IP || dport != PORT || ulen < 16'd8) return;
    plen = ulen - 16'd8;
    h_len = plen; h_sip = sip; h_sport = sport;
    e.idx = h + 41; e.vld = 1'b0; e.dat = 8'h00; e.st = 1'b1; e.dn = (plen == 16'd0);
    e.er = 1'b0; e.len = h_len; e.sip = h_sip; e.sport = h_sport;
    exp_q.push_back(e);
    for (int k = 0; k < int'(plen); k++) begin
      if (h + 42 + k < n) begin
        e.idx = h + 42 + k; e.vld = 1'b1; e.dat = fb[h + 42 + k]; e.st = 1'b0;
        e.dn = (k == int'(plen) - 1); e.er = 1'b0;
        exp_q.push_back(e);
      end
    end
    if (plen != 16'd0 && n < h + 42 + int'(plen)) begin
      e.idx = n; e.vld = 1'b0; e.dat = 8'h00; e.st = 1'b0; e.dn = 1'b0; e.er = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(posedge e_rxc); #1;
      e_rxdv = 1'b1; e_rxd = fb[i]; drv_cyc[i] = cyc;
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge e_rxc); #1;
      e_rxdv = 1'b0; e_rxd = 8'h00;
      if (g == 0) drv_cyc[n] = cyc;
    end
  endtask

  task automatic run_frame(input int n, input int gap);
    model(n);
    drive(n, gap);
  endtask

  task automatic drain();
    repeat (4) @(posedge e_rxc);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: every cycle with any output strobe must match the next expected event, including timing.
  always @(negedge e_rxc) begin
    if (mon_en && (data_o_valid || frame_start || frame_done || frame_err)) begin
      if (data_o_valid) vld_cnt++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: vld=%0b st=%0b dn=%0b er=%0b at cycle %0d, none required",
                 data_o_valid, frame_start, frame_done, frame_err, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_cycle", cyc, drv_cyc[mon_e.idx] + 1);
        chk("data_o_valid", {31'h0, data_o_valid}, {31'h0, mon_e.vld});
        if (mon_e.vld) chk("data_o", {24'h0, data_o}, {24'h0, mon_e.dat});
        chk("frame_start", {31'h0, frame_start}, {31'h0, mon_e.st});
        chk("frame_done", {31'h0, frame_done}, {31'h0, mon_e.dn});
        chk("frame_err", {31'h0, frame_err}, {31'h0, mon_e.er});
        chk("rx_data_length", {16'h0, rx_data_length}, {16'h0, mon_e.len});
        chk("rx_src_ip", rx_src_ip, mon_e.sip);
        chk("rx_src_port", {16'h0, rx_src_port}, {16'h0, mon_e.sport});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data_o"}, {24'h0, data_o}, 32'h0);
    chk({tag, "_valid"}, {31'h0, data_o_valid}, 32'h0);
    chk({tag, "_start"}, {31'h0, frame_start}, 32'h0);
    chk({tag, "_done"}, {31'h0, frame_done}, 32'h0);
    chk({tag, "_err"}, {31'h0, frame_err}, 32'h0);
    chk({tag, "_len"}, {16'h0, rx_data_length}, 32'h0);
    chk({tag, "_src_ip"}, rx_src_ip, 32'h0);
    chk({tag, "_src_port"}, {16'h0, rx_src_port}, 32'h0);
  endtask

  initial begin
    int n, v0, r;
    logic [47:0] dmac;
    logic [15:0] ulen;
    e_rxdv = 1'b0; e_rxd = 8'h00; reset_n = 1'b0;
    repeat (3) @(posedge e_rxc);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(posedge e_rxc);
    #1;

    // Broadcast frame, 4-byte payload DE AD BE EF
    build(7, BCAST, 16'h0800, 8'h45, 8'h11, IP, 32'h0A000001, 16'd1234, PORT, 16'd12, 4);
    fb[50] = 8'hDE; fb[51] = 8'hAD; fb[52] = 8'hBE; fb[53] = 8'hEF;
    run_frame(fb.size(), 2);
    drain();
    chk("directed_len", {16'h0, rx_data_length}, 32'd4);

    // Rejected frames: wrong port, TCP, ARP; held length must stay 4
    build(7, BCAST, 16'h0800, 8'h45, 8'h11, IP, 32'h0A000009, 16'd1, 16'd8081, 16'd12, 4);
    run_frame(fb.size(), 1);
    build(7, MAC, 16'h0800, 8'h45, 8'h06, IP, 32'h0A000009, 16'd1, PORT, 16'd12, 4);
    run_frame(fb.size(), 1);
    build(7, MAC, 16'h0806, 8'h45, 8'h11, IP, 32'h0A000009, 16'd1, PORT, 16'd12, 4);
    run_frame(fb.size(), 1);
    drain();
    chk("reject_len_held", {16'h0, rx_data_length}, 32'd4);
    chk("reject_ip_held", rx_src_ip, 32'h0A000001);

    // Padding/FCS suppression
    v0 = vld_cnt;
    build(7, MAC, 16'h0800, 8'h45, 8'h11, IP, 32'h0A000002, 16'd77, PORT, 16'd26, 18);
    run_frame(fb.size(), 1);
    build(7, MAC, 16'h0800, 8'h45, 8'h11, IP, 32'h0A000003, 16'd78, PORT, 16'd14, 6);
    run_frame(fb.size(), 1);
    drain();
    chk("pad_vld_count", vld_cnt - v0, 32'd24);

    // Truncation after 2 payload bytes, then a frame after one idle cycle
    build(7, MAC, 16'h0800, 8'h45, 8'h11, IP, 32'h0A000004, 16'd99, PORT, 16'd12, 4);
    run_frame(8 + 42 + 2, 1);
    build(7, MAC, 16'h0800, 8'h45, 8'h11, IP, 32'h0A000005, 16'd100, PORT, 16'd12, 4);
    run_frame(fb.size(), 1);
    drain();
    chk("after_trunc_ip", rx_src_ip, 32'h0A000005);

    // Zero-length and illegal-length datagrams
    build(7, MAC, 16'h0800, 8'h45, 8'h11, IP, 32'h0A000006, 16'd5, PORT, 16'd8, 0);
    run_frame(fb.size(), 1);
    drain();
    chk("zero_len", {16'h0, rx_data_length}, 32'd0);
    build(7, MAC, 16'h0800, 8'h45, 8'h11, IP, 32'h0A000007, 16'd6, PORT, 16'd5, 4);
    run_frame(fb.size(), 1);
    drain();
    chk("short_len_src_ip_held", rx_src_ip, 32'h0A000006);

    // Reset mid-payload
    mon_en = 1'b0;
    build(7, MAC, 16'h0800, 8'h45, 8'h11, IP, 32'hAC100001, 16'd1111, PORT, 16'd18, 10);
    n = fb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge e_rxc); #1;
      e_rxdv = 1'b1; e_rxd = fb[i];
      if (i == 53) begin
        #2;
        chk("pre_rst_valid", {31'h0, data_o_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
      end
      if (i == 55) reset_n = 1'b1;
    end
    @(posedge e_rxc); #1;
    e_rxdv = 1'b0; e_rxd = 8'h00;
    chk_all_zero("after_rst");
    exp_q.delete();
    h_len = 16'd0; h_sip = 32'd0; h_sport = 16'd0;
    mon_en = 1'b1;
    build(7, MAC, 16'h0800, 8'h45, 8'h11, IP, 32'h0A0B0C0D, 16'd4321, PORT, 16'd12, 4);
    run_frame(fb.size(), 2);
    drain();
    chk("post_rst_src_ip", rx_src_ip, 32'h0A0B0C0D);
    chk("post_rst_src_port", {16'h0, rx_src_port}, 32'd4321);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      dmac = (r < 5) ? MAC : (r < 8) ? BCAST : {16'h1234, 32'($urandom)};
      ulen = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 7)) : 16'(8 + $urandom_range(0, 30));
      build($urandom_range(1, 8), dmac,
            ($urandom_range(0, 9) == 0) ? 16'h86DD : 16'h0800,
            ($urandom_range(0, 14) == 0) ? 8'h46 : 8'h45,
            ($urandom_range(0, 9) == 0) ? 8'h06 : 8'h11,
            ($urandom_range(0, 9) == 0) ? 32'hC0A80003 : IP,
            $urandom, 16'($urandom_range(1, 65535)),
            ($urandom_range(0, 9) == 0) ? 16'd8081 : PORT,
            ulen, (ulen >= 16'd8) ? int'(ulen) - 8 : 4);
      n = fb.size();
      if ($urandom_range(0, 4) == 0) n = $urandom_range(1, fb.size() - 1);
      run_frame(n, $urandom_range(1, 3));
    end
    drain();
    chk("final_len_held", {16'h0, rx_data_length}, {16'h0, h_len});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
